// File: rtl/red_pitaya_relock_ctrl_if.sv
// Bundle between the register bank / PID / limit block and the relock supervisor.
// The master side drives configuration and monitor inputs; the slave side is the controller.
interface red_pitaya_relock_ctrl_if #(
  parameter int DW = 14,
  parameter int CW = 24
);

  logic                 enable_i;
  logic [1:0]           railed_i;
  logic signed [DW-1:0] mon_i;
  logic signed [DW-1:0] win_min_i;
  logic signed [DW-1:0] win_max_i;
  logic [CW-1:0]        hold_i;
  logic [CW-1:0]        settle_i;
  logic signed [DW-1:0] sweep_min_i;
  logic signed [DW-1:0] sweep_max_i;
  logic [DW-2:0]        sweep_step_i;

  logic                 pid_en_o;
  logic                 int_rst_o;
  logic signed [DW-1:0] sweep_o;
  logic [1:0]           state_o;
  logic [15:0]          relock_cnt_o;

  modport master (
    output enable_i, railed_i, mon_i, win_min_i, win_max_i, hold_i, settle_i,
           sweep_min_i, sweep_max_i, sweep_step_i,
    input  pid_en_o, int_rst_o, sweep_o, state_o, relock_cnt_o
  );

  modport slave (
    input  enable_i, railed_i, mon_i, win_min_i, win_max_i, hold_i, settle_i,
           sweep_min_i, sweep_max_i, sweep_step_i,
    output pid_en_o, int_rst_o, sweep_o, state_o, relock_cnt_o
  );

endinterface

// File: rtl/red_pitaya_relock_ctrl.sv
// Relock supervisor: detects loss of lock from the limit stage's railed flags,
// pulses the PID integrator reset, sweeps the actuator between bounds until the
// monitor settles in the lock window, then returns control to the PID.
module red_pitaya_relock_ctrl #(
  parameter int DW      = 14,
  parameter int CW      = 24,
  parameter int RST_CYC = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  red_pitaya_relock_ctrl_if.slave  bus
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    LOCKED   = 2'd1,
    RESET    = 2'd2,
    SWEEP    = 2'd3
  } state_t;

  state_t               state;
  logic                 pid_en;
  logic                 int_rst;
  logic signed [DW-1:0] sweep;
  logic                 dir_up;
  logic [15:0]          relock_cnt;
  logic [CW-1:0]        rail_cnt;
  logic [CW-1:0]        settle_cnt;
  logic [RW-1:0]        rst_cnt;

  logic signed [DW:0]   cur_x;
  logic signed [DW:0]   step_x;
  logic signed [DW:0]   smin_x;
  logic signed [DW:0]   smax_x;
  logic signed [DW:0]   sum_up;
  logic signed [DW:0]   sum_dn;
  logic signed [DW-1:0] sweep_next;
  logic                 dir_next;
  logic [CW-1:0]        settle_thr;
  logic                 in_win;

  // One extra bit of headroom so the step can never wrap past a bound.
  assign cur_x  = {sweep[DW-1], sweep};
  assign step_x = $signed({2'b00, bus.sweep_step_i});
  assign smin_x = {bus.sweep_min_i[DW-1], bus.sweep_min_i};
  assign smax_x = {bus.sweep_max_i[DW-1], bus.sweep_max_i};
  assign sum_up = cur_x + step_x;
  assign sum_dn = cur_x - step_x;

  assign settle_thr = (bus.settle_i == '0) ? CW'(1) : bus.settle_i;
  assign in_win     = (bus.mon_i >= bus.win_min_i) && (bus.mon_i <= bus.win_max_i);

  // Triangle sweep: bounce off each bound, clamping onto it when a step would overshoot.
  always_comb begin
    sweep_next = sweep;
    dir_next   = dir_up;
    if (smin_x >= smax_x) begin
      sweep_next = bus.sweep_min_i;
    end else if (bus.sweep_step_i != '0) begin
      if (dir_up) begin
        if (sum_up >= smax_x) begin
          sweep_next = bus.sweep_max_i;
          dir_next   = 1'b0;
        end else begin
          sweep_next = sum_up[DW-1:0];
        end
      end else begin
        if (sum_dn <= smin_x) begin
          sweep_next = bus.sweep_min_i;
          dir_next   = 1'b1;
        end else begin
          sweep_next = sum_dn[DW-1:0];
        end
      end
    end
  end

  // Supervisor FSM with registered outputs; disable overrides every transition.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= DISABLED;
      pid_en     <= 1'b0;
      int_rst    <= 1'b0;
      sweep      <= '0;
      dir_up     <= 1'b1;
      relock_cnt <= '0;
      rail_cnt   <= '0;
      settle_cnt <= '0;
      rst_cnt    <= '0;
    end else if (!bus.enable_i) begin
      state      <= DISABLED;
      pid_en     <= 1'b0;
      int_rst    <= 1'b0;
      sweep      <= '0;
      dir_up     <= 1'b1;
      rail_cnt   <= '0;
      settle_cnt <= '0;
      rst_cnt    <= '0;
    end else begin
      case (state)
        DISABLED: begin
          state    <= LOCKED;
          pid_en   <= 1'b1;
          rail_cnt <= '0;
        end
        LOCKED: begin
          if ((bus.hold_i != '0) && (rail_cnt >= bus.hold_i)) begin
            state      <= RESET;
            pid_en     <= 1'b0;
            int_rst    <= 1'b1;
            sweep      <= bus.sweep_min_i;
            dir_up     <= 1'b1;
            rst_cnt    <= '0;
            rail_cnt   <= '0;
            relock_cnt <= (&relock_cnt) ? relock_cnt : relock_cnt + 16'd1;
          end else if (bus.railed_i != 2'b00) begin
            rail_cnt <= (&rail_cnt) ? rail_cnt : rail_cnt + CW'(1);
          end else begin
            rail_cnt <= '0;
          end
        end
        RESET: begin
          if (rst_cnt == RST_LAST) begin
            state      <= SWEEP;
            int_rst    <= 1'b0;
            settle_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        SWEEP: begin
          if (settle_cnt >= settle_thr) begin
            state      <= LOCKED;
            pid_en     <= 1'b1;
            rail_cnt   <= '0;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= in_win ? ((&settle_cnt) ? settle_cnt : settle_cnt + CW'(1)) : '0;
            sweep      <= sweep_next;
            dir_up     <= dir_next;
          end
        end
        default: begin
          state <= DISABLED;
        end
      endcase
    end
  end

  assign bus.state_o      = state;
  assign bus.pid_en_o     = pid_en;
  assign bus.int_rst_o    = int_rst;
  assign bus.sweep_o      = sweep;
  assign bus.relock_cnt_o = relock_cnt;

endmodule

// File: tb/tb_red_pitaya_relock_ctrl.sv
// Testbench for the relock supervisor: directed scenarios with hand-computed
// expectations plus randomized traffic, all checked every cycle against a
// mode-level behavioural model.
module tb_red_pitaya_relock_ctrl;

  localparam int DW      = 14;
  localparam int CW      = 24;
  localparam int RST_CYC = 16;

  logic clk_i = 1'b0;
  logic rstn_i;

  always #5 clk_i = ~clk_i;

  red_pitaya_relock_ctrl_if #(.DW(DW), .CW(CW)) bus ();

  red_pitaya_relock_ctrl #(.DW(DW), .CW(CW), .RST_CYC(RST_CYC)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model: mode 0 off, 1 PID in control, 2 integrator reset, 3 searching.
  int mMode;
  int mRail;
  int mSettle;
  int mRstLeft;
  int mSweep;
  int mRelocks;
  bit mUp;

  task automatic modelReset();
    mMode    = 0;
    mRail    = 0;
    mSettle  = 0;
    mRstLeft = 0;
    mSweep   = 0;
    mUp      = 1'b1;
    mRelocks = 0;
  endtask

  task automatic modelStep();
    int smin, smax, step, hold, thr, mon, v;
    smin = int'(bus.sweep_min_i);
    smax = int'(bus.sweep_max_i);
    step = int'(bus.sweep_step_i);
    hold = int'(bus.hold_i);
    thr  = (bus.settle_i == 0) ? 1 : int'(bus.settle_i);
    mon  = int'(bus.mon_i);
    if (!bus.enable_i) begin
      mMode = 0; mRail = 0; mSettle = 0; mRstLeft = 0; mSweep = 0; mUp = 1'b1;
    end else if (mMode == 0) begin
      mMode = 1; mRail = 0;
    end else if (mMode == 1) begin
      if (hold != 0 && mRail >= hold) begin
        mMode = 2; mRail = 0; mRstLeft = RST_CYC - 1; mSweep = smin; mUp = 1'b1;
        mRelocks = (mRelocks < 65535) ? mRelocks + 1 : 65535;
      end else begin
        mRail = (bus.railed_i != 0) ? mRail + 1 : 0;
      end
    end else if (mMode == 2) begin
      if (mRstLeft == 0) begin
        mMode = 3; mSettle = 0;
      end else begin
        mRstLeft--;
      end
    end else begin
      if (mSettle >= thr) begin
        mMode = 1; mRail = 0; mSettle = 0;
      end else begin
        mSettle = (mon >= int'(bus.win_min_i) && mon <= int'(bus.win_max_i)) ? mSettle + 1 : 0;
        if (smin >= smax) begin
          mSweep = smin;
        end else if (step != 0) begin
          v = mUp ? mSweep + step : mSweep - step;
          if (mUp && v >= smax) begin
            mSweep = smax; mUp = 1'b0;
          end else if (!mUp && v <= smin) begin
            mSweep = smin; mUp = 1'b1;
          end else begin
            mSweep = v;
          end
        end
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("state_o",      int'(bus.state_o),      mMode);
    cmp("pid_en_o",     int'(bus.pid_en_o),     (mMode == 1) ? 1 : 0);
    cmp("int_rst_o",    int'(bus.int_rst_o),    (mMode == 2) ? 1 : 0);
    cmp("sweep_o",      int'(bus.sweep_o),      mSweep);
    cmp("relock_cnt_o", int'(bus.relock_cnt_o), mRelocks);
  endtask

  // Advance one clock: predict, clock the DUT, then compare on the falling edge.
  task automatic cycle();
    modelStep();
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput();
  endtask

  bit railPhase = 1'b0;

  task automatic randomConfig();
    int c, hw, a;
    bus.sweep_min_i  = DW'(int'($urandom_range(8000, 0)) - 8000);
    bus.sweep_max_i  = DW'(int'($urandom_range(9000, 0)) - 1000);
    bus.sweep_step_i = ($urandom_range(9, 0) == 0) ? '0 : (DW-1)'($urandom_range(4000, 1));
    bus.hold_i       = CW'($urandom_range(12, 0));
    bus.settle_i     = CW'($urandom_range(6, 0));
    c  = int'($urandom_range(12000, 0)) - 6000;
    hw = int'($urandom_range(800, 0));
    a  = ($urandom_range(7, 0) == 0) ? -1 : 1;
    bus.win_min_i = DW'(c - a * hw);
    bus.win_max_i = DW'(c + a * hw);
  endtask

  task automatic applyStimulus();
    int lo, hi;
    if ($urandom_range(19, 0) == 0) railPhase = ~railPhase;
    bus.railed_i = railPhase ? 2'($urandom_range(3, 1)) : 2'b00;
    lo = int'(bus.win_min_i);
    hi = int'(bus.win_max_i);
    if (lo > hi) begin lo = int'(bus.win_max_i); hi = int'(bus.win_min_i); end
    if ($urandom_range(9, 0) < 6)
      bus.mon_i = DW'(lo - 100 + int'($urandom_range(hi - lo + 200, 0)));
    else
      bus.mon_i = DW'(int'($urandom_range(16000, 0)) - 8000);
    bus.enable_i = ($urandom_range(499, 0) != 0);
    if ($urandom_range(199, 0) == 0) bus.hold_i = CW'($urandom_range(12, 0));
    if ($urandom_range(199, 0) == 0) bus.settle_i = CW'($urandom_range(6, 0));
  endtask

  initial begin
    int cnt;
    int triExp [8];
    triExp = '{-4000, -1000, 2000, 4000, 1000, -2000, -4000, -1000};

    bus.enable_i     = 1'b0;
    bus.railed_i     = 2'b00;
    bus.mon_i        = DW'(2000);
    bus.win_min_i    = DW'(-100);
    bus.win_max_i    = DW'(100);
    bus.hold_i       = CW'(10);
    bus.settle_i     = CW'(5);
    bus.sweep_min_i  = DW'(-4000);
    bus.sweep_max_i  = DW'(4000);
    bus.sweep_step_i = (DW-1)'(3000);

    // Reset and enable.
    rstn_i = 1'b0;
    modelReset();
    repeat (2) @(negedge clk_i);
    checkOutput();
    cmp("reset_state", int'(bus.state_o), 0);
    cmp("reset_sweep", int'(bus.sweep_o), 0);
    cmp("reset_relock", int'(bus.relock_cnt_o), 0);
    rstn_i = 1'b1;
    bus.enable_i = 1'b1;
    cycle();
    cmp("enable_state", int'(bus.state_o), 1);
    cmp("enable_pid_en", int'(bus.pid_en_o), 1);

    // Lock loss with hold 10: RESET visible 11 edges after railed rises.
    bus.railed_i = 2'b10;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      cnt++;
      if (bus.state_o == 2'd2) break;
    end
    cmp("loss_latency", cnt, 11);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.int_rst_o) cnt++;
      else break;
    end
    cmp("int_rst_len", cnt, 16);
    cmp("relock_after_loss", int'(bus.relock_cnt_o), 1);

    // Triangle sweep with an unreachable window.
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cycle();
      cmp($sformatf("tri_%0d", k), int'(bus.sweep_o), triExp[k]);
    end

    // Relock: 4 in-window then one out, then 5 in-window.
    bus.railed_i = 2'b00;
    bus.mon_i = DW'(0);
    repeat (4) cycle();
    bus.mon_i = DW'(2000);
    cycle();
    cmp("short_settle_state", int'(bus.state_o), 3);
    cmp("short_settle_sweep", int'(bus.sweep_o), -4000);
    bus.mon_i = DW'(0);
    repeat (5) cycle();
    cmp("settled_not_yet", int'(bus.state_o), 3);
    cycle();
    cmp("relock_state", int'(bus.state_o), 1);
    cmp("relock_pid_en", int'(bus.pid_en_o), 1);
    cmp("relock_sweep_hold", int'(bus.sweep_o), -2000);

    // 9-cycle railed pulse then a clear cycle: stays locked.
    bus.railed_i = 2'b01;
    repeat (9) cycle();
    bus.railed_i = 2'b00;
    repeat (3) cycle();
    cmp("pulse9_state", int'(bus.state_o), 1);

    // hold 0 disables relock.
    bus.hold_i = '0;
    bus.railed_i = 2'b11;
    repeat (1000) cycle();
    cmp("hold0_state", int'(bus.state_o), 1);

    // Degenerate sweep bounds and an empty window.
    bus.hold_i = CW'(3);
    bus.sweep_min_i = DW'(1000);
    bus.sweep_max_i = DW'(1000);
    bus.win_min_i = DW'(50);
    bus.win_max_i = DW'(-50);
    bus.mon_i = DW'(0);
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (bus.state_o == 2'd3) break;
    end
    cmp("reach_sweep", int'(bus.state_o), 3);
    for (int i = 0; i < 20; i++) begin
      cycle();
      cmp("flat_sweep", int'(bus.sweep_o), 1000);
      cmp("empty_window_state", int'(bus.state_o), 3);
    end

    // Disable mid-sweep keeps the lock-loss count.
    bus.enable_i = 1'b0;
    cycle();
    cmp("disable_state", int'(bus.state_o), 0);
    cmp("disable_sweep", int'(bus.sweep_o), 0);
    cmp("disable_relock", int'(bus.relock_cnt_o), 2);

    // Asynchronous reset in the middle of RESET.
    bus.enable_i = 1'b1;
    bus.hold_i = CW'(2);
    bus.railed_i = 2'b11;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (bus.state_o == 2'd2) break;
    end
    cmp("reach_reset", int'(bus.state_o), 2);
    repeat (2) cycle();
    rstn_i = 1'b0;
    #1;
    modelReset();
    cmp("async_int_rst", int'(bus.int_rst_o), 0);
    cmp("async_state", int'(bus.state_o), 0);
    checkOutput();
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Randomized traffic.
    for (int e = 0; e < 40; e++) begin
      randomConfig();
      for (int c = 0; c < 400; c++) begin
        applyStimulus();
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
